// File: rtl/delta_adc_pkg.sv
// ============================================================================
// Module   : delta_adc_pkg
// Brief    : Shared FSM encodings and code-arithmetic helpers for delta_adc_seq.
// Revision : 1.0
// ============================================================================
`default_nettype none

package delta_adc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_SAMPLE = 3'd2,
        ST_UPDATE = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    function automatic int unsigned mid_code(input int unsigned dw);
        return 32'd1 << (dw - 32'd1);
    endfunction

    // Saturating step: result always lies within [0, 2^dw-1].
    function automatic logic [31:0] clamp_step(input logic [31:0] code,
                                               input logic [31:0] step,
                                               input logic        up,
                                               input int unsigned dw);
        logic [32:0] max_code;
        logic [32:0] sum;
        max_code = (33'd1 << dw) - 33'd1;
        sum      = {1'b0, code} + {1'b0, step};
        if (up)
            return (sum > max_code) ? max_code[31:0] : sum[31:0];
        else
            return (step > code) ? 32'd0 : (code - step);
    endfunction

endpackage

`default_nettype wire

// File: rtl/delta_adc_sync.sv
// ============================================================================
// Module   : delta_adc_sync
// Brief    : Two-flop synchronizer for the asynchronous comparator output.
// Revision : 1.0
// ============================================================================
`default_nettype none

module delta_adc_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule

`default_nettype wire

// File: rtl/delta_adc_seq.sv
// ============================================================================
// Module   : delta_adc_seq
// Brief    : Delta-modulation ADC conversion sequencer with valid/ready output.
//            Optional adaptive step size: define DELTA_ADC_ADAPTIVE_STEP_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module delta_adc_seq
    import delta_adc_pkg::*;
#(
    parameter int DW     = 8,
    parameter int OSR    = 16,
    parameter int SETTLE = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          start,
    input  logic          cont,
    input  logic          comp_in,
    output logic [DW-1:0] dac_code,
    output logic          dac_le,
    output logic [DW-1:0] res_data,
    output logic          res_valid,
    input  logic          res_ready,
    output logic          busy,
    output logic          overrun
);

    localparam int            CW          = $clog2(OSR + 1);
    localparam int            SW          = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [DW-1:0] MID_CODE    = DW'(mid_code(DW));
    localparam logic [CW-1:0] LAST_SAMPLE = CW'(OSR - 1);
    localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE - 1);

    state_t        r_state;
    state_t        w_next;
    logic [CW-1:0] r_samp;
    logic [SW-1:0] r_settle;
    logic          r_dir;
    logic          w_comp_sync;
    logic [DW-1:0] w_step;
    logic [DW-1:0] w_code_next;
    logic          w_conv_start;

    delta_adc_sync u_sync (
        .clk (clk),
        .rst (rst),
        .d   (comp_in),
        .q   (w_comp_sync)
    );

    // A new conversion begins on an accepted start or a continuous-mode rollover.
    assign w_conv_start = en && (((r_state == ST_IDLE) && start) ||
                                 ((r_state == ST_DONE) && cont));

    assign w_code_next = DW'(clamp_step(32'(dac_code), 32'(w_step), r_dir, DW));
    assign busy        = (r_state != ST_IDLE);

`ifdef DELTA_ADC_ADAPTIVE_STEP_EN
    localparam logic [DW-1:0] STEP_MAX = DW'(1) << (DW - 3);

    logic [DW-1:0] r_step;
    logic [1:0]    r_run;
    logic          r_prev_dir;
    logic          r_have_prev;
    logic          w_flip;

    assign w_flip = r_have_prev && (r_dir != r_prev_dir);
    assign w_step = w_flip ? DW'(1) : r_step;

    always_ff @(posedge clk) begin
        if (rst || w_conv_start) begin
            r_step      <= DW'(1);
            r_run       <= 2'd0;
            r_prev_dir  <= 1'b0;
            r_have_prev <= 1'b0;
        end else if (en && (r_state == ST_UPDATE)) begin
            r_have_prev <= 1'b1;
            r_prev_dir  <= r_dir;
            if (w_flip) begin
                r_step <= DW'(1);
                r_run  <= 2'd0;
            end else if (r_run == 2'd2) begin
                r_run  <= 2'd0;
                r_step <= (r_step >= STEP_MAX) ? STEP_MAX : (r_step << 1);
            end else begin
                r_run <= r_run + 2'd1;
            end
        end
    end
`else
    assign w_step = DW'(1);
`endif

    always_comb begin
        w_next = r_state;
        if (!en) begin
            w_next = ST_IDLE;
        end else begin
            unique case (r_state)
                ST_IDLE:   if (start) w_next = ST_SETTLE;
                ST_SETTLE: if (r_settle == '0) w_next = ST_SAMPLE;
                ST_SAMPLE: w_next = ST_UPDATE;
                ST_UPDATE: w_next = (r_samp == LAST_SAMPLE) ? ST_DONE : ST_SETTLE;
                ST_DONE:   w_next = cont ? ST_SETTLE : ST_IDLE;
                default:   w_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_samp    <= '0;
            r_settle  <= '0;
            r_dir     <= 1'b0;
            dac_code  <= MID_CODE;
            dac_le    <= 1'b0;
            res_data  <= '0;
            res_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            r_state <= w_next;
            dac_le  <= 1'b0;
            if (res_valid && res_ready)
                res_valid <= 1'b0;
            if (w_conv_start) begin
                r_samp   <= '0;
                r_settle <= SETTLE_LOAD;
            end
            if (en) begin
                unique case (r_state)
                    ST_IDLE: if (start) overrun <= 1'b0;
                    ST_SETTLE: if (r_settle != '0) r_settle <= r_settle - SW'(1);
                    ST_SAMPLE: r_dir <= w_comp_sync;
                    ST_UPDATE: begin
                        dac_code <= w_code_next;
                        dac_le   <= 1'b1;
                        r_samp   <= r_samp + CW'(1);
                        r_settle <= SETTLE_LOAD;
                    end
                    ST_DONE: begin
                        // Simultaneous acceptance keeps valid high with the fresh word.
                        res_data  <= dac_code;
                        res_valid <= 1'b1;
                        if (res_valid && !res_ready)
                            overrun <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_delta_adc_seq.sv
// ============================================================================
// Module   : tb_delta_adc_seq
// Brief    : Directed self-checking bench for delta_adc_seq (DW=8, OSR=16, SETTLE=4).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_delta_adc_seq;

    logic       clk = 1'b0;
    logic       rst, en, start, cont, comp_in, res_ready;
    logic [7:0] dac_code, res_data;
    logic       dac_le, res_valid, busy, overrun;

    int checks = 0;
    int errors = 0;

    delta_adc_seq #(.DW(8), .OSR(16), .SETTLE(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .start     (start),
        .cont      (cont),
        .comp_in   (comp_in),
        .dac_code  (dac_code),
        .dac_le    (dac_le),
        .res_data  (res_data),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .busy      (busy),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; start = 1'b0; cont = 1'b0;
        comp_in = 1'b0; res_ready = 1'b0;
        tick(3);
        checks++; if (dac_code !== 8'd128) begin errors++; $display("FAIL reset_dac_code: got %0d expected 128", dac_code); end
        checks++; if (res_data !== 8'd0) begin errors++; $display("FAIL reset_res_data: got %0d expected 0", res_data); end
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid: got %b expected 0", res_valid); end
        checks++; if (dac_le !== 1'b0) begin errors++; $display("FAIL reset_dac_le: got %b expected 0", dac_le); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        rst = 1'b0;
    endtask

    // Single conversion, comp held high; includes an ignored start while busy.
    task automatic test_single();
        int n_le = 0, first_le = -1, last_le = -1, rise = -1;
        logic prev_busy = 1'b0, busy_at_rise = 1'b1;
        comp_in = 1'b1;
        tick(3);
        pulse_start();
        for (int c = 1; c <= 130; c++) begin
            prev_busy = busy;
            tick();
            if (c == 50) start = 1'b1;
            if (c == 51) start = 1'b0;
            if (dac_le) begin
                n_le++;
                if (first_le < 0) first_le = c;
                last_le = c;
            end
            if (res_valid) begin
                rise = c;
                busy_at_rise = busy;
                break;
            end
        end
        checks++; if (n_le != 16) begin errors++; $display("FAIL single_le_count: got %0d expected 16", n_le); end
        checks++; if (first_le != 6) begin errors++; $display("FAIL single_first_le: got %0d expected 6", first_le); end
        checks++; if (last_le != 96) begin errors++; $display("FAIL single_last_le: got %0d expected 96", last_le); end
        checks++; if (rise != 97) begin errors++; $display("FAIL single_valid_latency: got %0d expected 97", rise); end
        checks++; if (res_data !== 8'd144) begin errors++; $display("FAIL single_res_data: got %0d expected 144", res_data); end
        checks++; if (prev_busy !== 1'b1) begin errors++; $display("FAIL single_busy_in_done: got %b expected 1", prev_busy); end
        checks++; if (busy_at_rise !== 1'b0) begin errors++; $display("FAIL single_busy_fall: got %b expected 0", busy_at_rise); end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL single_valid_drop: got %b expected 0", res_valid); end
    endtask

    // Nine continuous conversions from mid-scale; must saturate without wrapping.
    task automatic test_clamp(input logic up);
        int idx = 0;
        int expv = 128;
        do_reset();
        comp_in = up; cont = 1'b1; res_ready = 1'b1;
        tick(3);
        pulse_start();
        for (int c = 0; c < 9 * 97 + 40; c++) begin
            tick();
            if (res_valid) begin
                expv = up ? ((expv + 16 > 255) ? 255 : expv + 16)
                          : ((expv - 16 < 0) ? 0 : expv - 16);
                checks++;
                if (res_data !== 8'(expv)) begin
                    errors++;
                    $display("FAIL clamp_%s_result%0d: got %0d expected %0d", up ? "up" : "dn", idx, res_data, expv);
                end
                idx++;
                if (idx == 8) cont = 1'b0;
                if (idx == 9) break;
            end
        end
        checks++; if (idx != 9) begin errors++; $display("FAIL clamp_result_count: got %0d expected 9", idx); end
        checks++; if (dac_code !== (up ? 8'd255 : 8'd0)) begin errors++; $display("FAIL clamp_final_code: got %0d expected %0d", dac_code, up ? 255 : 0); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL clamp_busy_end: got %b expected 0", busy); end
        res_ready = 1'b0;
    endtask

    // comp_in flips after every DAC update so directions alternate 1,0,1,...
    task automatic test_toggle();
        int k = 0;
        do_reset();
        comp_in = 1'b1; cont = 1'b0; res_ready = 1'b0;
        tick(3);
        pulse_start();
        for (int c = 0; c < 130; c++) begin
            tick();
            if (dac_le) begin
                k++;
                checks++;
                if (dac_code !== ((k % 2 == 1) ? 8'd129 : 8'd128)) begin
                    errors++;
                    $display("FAIL toggle_code_step%0d: got %0d expected %0d", k, dac_code, (k % 2 == 1) ? 129 : 128);
                end
                comp_in = ~comp_in;
            end
            if (res_valid) break;
        end
        checks++; if (k != 16) begin errors++; $display("FAIL toggle_steps: got %0d expected 16", k); end
        checks++; if (res_data !== 8'd128) begin errors++; $display("FAIL toggle_res_data: got %0d expected 128", res_data); end
    endtask

    // Two unaccepted results set overrun; a start clears it; en low aborts.
    task automatic test_overrun();
        do_reset();
        comp_in = 1'b1; cont = 1'b1; res_ready = 1'b0;
        tick(3);
        pulse_start();
        for (int c = 0; c < 130 && !res_valid; c++) tick();
        checks++; if (res_data !== 8'd144 || res_valid !== 1'b1) begin errors++; $display("FAIL ovr_first_result: got %0d/%b expected 144/1", res_data, res_valid); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_first_flag: got %b expected 0", overrun); end
        cont = 1'b0;
        for (int c = 0; c < 130 && busy; c++) tick();
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_set: got %b expected 1", overrun); end
        checks++; if (res_data !== 8'd160) begin errors++; $display("FAIL ovr_res_data: got %0d expected 160", res_data); end
        pulse_start();
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_clear_on_start: got %b expected 0", overrun); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ovr_busy_after_start: got %b expected 1", busy); end
        en = 1'b0;
        tick();
        en = 1'b1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy); end
        checks++; if (res_valid !== 1'b1 || res_data !== 8'd160) begin errors++; $display("FAIL abort_result_kept: got %0d/%b expected 160/1", res_data, res_valid); end
        checks++; if (dac_code !== 8'd160) begin errors++; $display("FAIL abort_code_kept: got %0d expected 160", dac_code); end
    endtask

    // Consumer accepts in the very cycle DONE writes the next word.
    task automatic test_back_to_back();
        int n_le = 0;
        pulse_start();
        for (int c = 0; c < 130 && n_le < 16; c++) begin
            tick();
            if (dac_le) n_le++;
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid: got %b expected 1", res_valid); end
        checks++; if (res_data !== 8'd176) begin errors++; $display("FAIL b2b_res_data: got %0d expected 176", res_data); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL b2b_overrun: got %b expected 0", overrun); end
    endtask

    task automatic test_en_abort();
        int n_le = 0;
        do_reset();
        comp_in = 1'b1; cont = 1'b0; res_ready = 1'b0;
        tick(3);
        pulse_start();
        for (int c = 0; c < 60 && n_le < 5; c++) begin
            tick();
            if (dac_le) n_le++;
        end
        tick();
        en = 1'b0;
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL en_abort_busy: got %b expected 0", busy); end
        checks++; if (dac_code !== 8'd133) begin errors++; $display("FAIL en_abort_code: got %0d expected 133", dac_code); end
        checks++; if (res_valid !== 1'b0 || res_data !== 8'd0) begin errors++; $display("FAIL en_abort_result: got %0d/%b expected 0/0", res_data, res_valid); end
        pulse_start();
        tick(8);
        checks++; if (busy !== 1'b0 || dac_code !== 8'd133) begin errors++; $display("FAIL start_en_low: got busy=%b code=%0d expected 0/133", busy, dac_code); end
        en = 1'b1;
        pulse_start();
        tick(10);
        do_reset();
        checks++; if (dac_code !== 8'd128) begin errors++; $display("FAIL midrst_code: got %0d expected 128", dac_code); end
        checks++; if (busy !== 1'b0 || dac_le !== 1'b0) begin errors++; $display("FAIL midrst_busy_le: got %b/%b expected 0/0", busy, dac_le); end
        checks++; if (res_valid !== 1'b0 || overrun !== 1'b0 || res_data !== 8'd0) begin errors++; $display("FAIL midrst_result: got %0d/%b/%b expected 0/0/0", res_data, res_valid, overrun); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_clamp(1'b1);
        test_clamp(1'b0);
        test_toggle();
        test_overrun();
        test_back_to_back();
        test_en_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
